// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter
// Measures the period of a divided clock (sampled as data in the clk domain)
// over a fixed gate window. It reports the number of complete periods and
// their minimum, maximum and sum, all in clk cycles.
//
// Timing: the result registers and timeout load on the same edge that enters
// DONE. As a result, done, busy and valid results are all visible together
// during the single DONE cycle. The results then hold until the next accepted
// start clears them.

module clk_ratio_meter #(
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
    output logic [CNT_W-1:0] sum_cycles
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_EDGE = 2'd1,
        S_MEASURE   = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Input path: two-flop synchroniser plus a delay flop for edge detection
    logic r_sync1;
    logic r_sync2;
    logic r_dly;
    logic w_edge;

    // FSM state and measurement registers
    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_gate_cnt,   w_gate_cnt_nxt;
    logic [CNT_W-1:0] r_period_cnt, w_period_cnt_nxt;
    logic [CNT_W-1:0] r_edge_cnt,   w_edge_cnt_nxt;
    logic [CNT_W-1:0] r_sum,        w_sum_nxt;
    logic [CNT_W-1:0] r_min,        w_min_nxt;
    logic [CNT_W-1:0] r_max,        w_max_nxt;
    logic             w_accept;
    logic             w_set_timeout;

    // Registered results
    logic             r_timeout;
    logic [CNT_W-1:0] r_res_edge_cnt;
    logic [CNT_W-1:0] r_res_min;
    logic [CNT_W-1:0] r_res_max;
    logic [CNT_W-1:0] r_res_sum;

    // Synchronise div_in and keep a one-cycle-old copy for rising-edge detection
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= div_in;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    // The latency through the sync/delay chain is fixed, so periods are exact
    assign w_edge = r_sync2 & ~r_dly;

    // Next-state and next-value logic for the measurement FSM
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state     = r_state;
        w_gate_cnt_nxt   = r_gate_cnt;
        w_period_cnt_nxt = r_period_cnt;
        w_edge_cnt_nxt   = r_edge_cnt;
        w_sum_nxt        = r_sum;
        w_min_nxt        = r_min;
        w_max_nxt        = r_max;
        w_accept         = 1'b0;
        w_set_timeout    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept         = 1'b1;
                    w_next_state     = S_WAIT_EDGE;
                    w_gate_cnt_nxt   = CNT_ZERO;
                    w_period_cnt_nxt = CNT_ZERO;
                    w_edge_cnt_nxt   = CNT_ZERO;
                    w_sum_nxt        = CNT_ZERO;
                    w_min_nxt        = CNT_MAX;
                    w_max_nxt        = CNT_ZERO;
                end
            end

            S_WAIT_EDGE: begin
                w_gate_cnt_nxt = r_gate_cnt + CNT_ONE;
                if (w_edge) begin
                    // The first edge only opens the gate; it ends no period
                    w_next_state     = S_MEASURE;
                    w_gate_cnt_nxt   = CNT_ZERO;
                    w_period_cnt_nxt = CNT_ONE;
                end else if (r_gate_cnt == GATE_LAST) begin
                    w_next_state  = S_DONE;
                    w_set_timeout = 1'b1;
                end
            end

            S_MEASURE: begin
                w_gate_cnt_nxt   = r_gate_cnt + CNT_ONE;
                w_period_cnt_nxt = (r_period_cnt == CNT_MAX) ? CNT_MAX
                                                             : r_period_cnt + CNT_ONE;
                if (w_edge) begin
                    w_edge_cnt_nxt   = r_edge_cnt + CNT_ONE;
                    w_sum_nxt        = r_sum + r_period_cnt;
                    w_min_nxt        = (r_period_cnt < r_min) ? r_period_cnt : r_min;
                    w_max_nxt        = (r_period_cnt > r_max) ? r_period_cnt : r_max;
                    w_period_cnt_nxt = CNT_ONE;
                end
                // An edge on the final gate cycle is counted above; any
                // partial period still in progress is dropped here
                if (r_gate_cnt == GATE_LAST) begin
                    w_next_state = S_DONE;
                end
            end

            S_DONE: begin
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State and measurement register update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_gate_cnt   <= CNT_ZERO;
            r_period_cnt <= CNT_ZERO;
            r_edge_cnt   <= CNT_ZERO;
            r_sum        <= CNT_ZERO;
            r_min        <= CNT_ZERO;
            r_max        <= CNT_ZERO;
        end else begin
            r_state      <= w_next_state;
            r_gate_cnt   <= w_gate_cnt_nxt;
            r_period_cnt <= w_period_cnt_nxt;
            r_edge_cnt   <= w_edge_cnt_nxt;
            r_sum        <= w_sum_nxt;
            r_min        <= w_min_nxt;
            r_max        <= w_max_nxt;
        end
    end

    // Result registers: cleared on an accepted start, loaded on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout      <= 1'b0;
            r_res_edge_cnt <= CNT_ZERO;
            r_res_min      <= CNT_ZERO;
            r_res_max      <= CNT_ZERO;
            r_res_sum      <= CNT_ZERO;
        end else if (w_accept) begin
            r_timeout      <= 1'b0;
            r_res_edge_cnt <= CNT_ZERO;
            r_res_min      <= CNT_ZERO;
            r_res_max      <= CNT_ZERO;
            r_res_sum      <= CNT_ZERO;
        end else if (w_next_state == S_DONE && r_state != S_DONE) begin
            r_timeout      <= w_set_timeout;
            r_res_edge_cnt <= w_edge_cnt_nxt;
            // With no period measured, min would still be all-ones; report 0
            r_res_min      <= (w_edge_cnt_nxt == CNT_ZERO) ? CNT_ZERO : w_min_nxt;
            r_res_max      <= w_max_nxt;
            r_res_sum      <= w_sum_nxt;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign timeout    = r_timeout;
    assign edge_cnt   = r_res_edge_cnt;
    assign min_period = r_res_min;
    assign max_period = r_res_max;
    assign sum_cycles = r_res_sum;

endmodule
